instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream feeder for the multi-cycle control unit.
- Owns the program counter and reads 16-bit instructions from a synchronous-read instruction ROM. Presents each instruction on a stable bus, then pulses run and waits for the control unit's done before fetching the next one.
- Handles start/stop, a HALT opcode, PC wrap-around, and a watchdog against a control unit that never completes.

Parameters:
- INSTR_W, 16, instruction width (matches control unit decode fields [15:0])
- ADDR_W, 8, ROM address / PC width
- PROG_LEN, 256, number of valid ROM words; PC wraps from PROG_LEN-1 to 0
- HALT_OP, 16'hFFFF, instruction encoding that stops the fetch loop (never issued to control unit)
- TIMEOUT, 15, max cycles from run pulse to done before watchdog error

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level/pulse; begins fetching from current PC when IDLE or HALTED
- stop  in  1  pulse; finish in-flight instruction, then go to HALTED
- mem_rd_en  out  1  ROM read strobe
- mem_addr  out  ADDR_W  ROM address (= pc)
- mem_rdata  in  INSTR_W  ROM data, valid the cycle after mem_rd_en
- instruction  out  INSTR_W  registered instruction to control unit, stable from run until done
- run  out  1  one-cycle pulse: instruction valid, control unit may begin
- done  in  1  control unit completion (sampled high in any cycle of EXEC)
- pc  out  ADDR_W  address of instruction currently held
- busy  out  1  high in FETCH, WAIT_MEM, ISSUE, EXEC
- halted  out  1  high in HALTED
- wd_err  out  1  sticky watchdog error, cleared only by reset or start

Behaviour:
- Reset (async, reset low): state=IDLE; pc=0; instruction=0; run=0; mem_rd_en=0; mem_addr=0; busy=0; halted=0; wd_err=0; wd counter=0; stop_pend=0. Reset mid-instruction abandons it; no further run pulses.
- States: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, HALTED.
- IDLE: start -> FETCH; wd_err cleared.
- FETCH: mem_rd_en=1, mem_addr=pc, for exactly one cycle -> WAIT_MEM.
- WAIT_MEM: capture mem_rdata.
  - If HALT_OP, do not load instruction; go to HALTED; pc unchanged, pointing at HALT word.
  - Else load instruction -> ISSUE.
- ISSUE: run=1 for one cycle; clear wd counter -> EXEC.
- EXEC: run=0; wd counter increments each cycle.
  - done=1: pc <= (pc==PROG_LEN-1) ? 0 : pc+1. Then go to HALTED if stop_pend or stop this cycle, else FETCH.
  - Counter reaches TIMEOUT without done: wd_err=1 -> HALTED; pc not advanced.
  - done and timeout in the same cycle: done wins.
- Latency: start to run = 3 cycles (FETCH, WAIT_MEM, ISSUE). Steady-state overhead per instruction = 3 cycles beyond the control unit's execute time.
- stop: in IDLE or HALTED, ignored. In FETCH/WAIT_MEM/ISSUE/EXEC, sets stop_pend. The current instruction is still issued and completed; stop_pend cleared on entry to HALTED.
- HALTED: halted=1.
  - start -> FETCH; wd_err cleared.
  - If halted on HALT_OP, pc is advanced (with wrap) on restart, so execution resumes past the HALT word.
- start while busy: ignored. start and stop in the same cycle from IDLE: start wins, stop_pend set.
- done outside EXEC: ignored.
- instruction must not change between ISSUE and the EXEC exit cycle.
- Width rules:
  - pc wrap is compared against PROG_LEN-1, not 2^ADDR_W.
  - Watchdog counter is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package: fetch state enum (fetch_state_t, 3 bits), HALT_OP constant, INSTR_W, and instruction-field constants shared with the control unit (dst [15:13], src [12:10], alu_sel [6:3], mode [2]).
- One sub-module: fetch_watchdog (clear, enable, saturating count, timeout flag). Everything else inline.

Test Plan:
- ROM[0..2]={16'h2018,16'h4420,16'hFFFF}; control-unit model returns done 3 cycles after run; start at t0 -> run at t0+3; instruction=16'h2018 then 16'h4420; halted=1 with pc=2; exactly 2 run pulses.
- PROG_LEN=4, ROM words 0..3 non-HALT; start -> pc sequence 0,1,2,3,0 observed at successive run pulses.
- stop pulsed 1 cycle after run of instruction at pc=1 -> done accepted, pc=2, halted=1, no further mem_rd_en. Then start -> next run carries ROM[2].
- Control-unit model never asserts done -> wd_err=1 and halted=1 exactly TIMEOUT cycles after run; pc unchanged. start -> wd_err=0 and the same instruction is re-issued.
- Assert reset low during EXEC at pc=5 -> all outputs return to reset values immediately (async); run never asserted until a new start; next fetch reads address 0.
- done asserted in ISSUE and in IDLE -> ignored: pc unchanged, no state change.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the control unit it feeds:
// fetch state encoding, instruction width, HALT encoding and decode field positions.
package instr_fetch_unit_pkg;

   localparam int INSTR_W = 16;
   localparam logic [INSTR_W-1:0] HALT_OP = 16'hFFFF;

   // Decode fields of the control unit's instruction word.
   localparam int DST_MSB     = 15;
   localparam int DST_LSB     = 13;
   localparam int SRC_MSB     = 12;
   localparam int SRC_LSB     = 10;
   localparam int ALU_SEL_MSB = 6;
   localparam int ALU_SEL_LSB = 3;
   localparam int MODE_BIT    = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAIT_MEM = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_EXEC     = 3'd4,
      ST_HALTED   = 3'd5
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_watchdog.sv
// Saturating cycle counter that flags a control unit which has not answered within
// TIMEOUT execute cycles; the flag is raised during the TIMEOUT-th enabled cycle.
module fetch_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   // The count reaches TIMEOUT on the edge that ends this cycle.
   assign o_timeout = i_enable && (r_count >= CNT_LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Program-counter owner that fetches 16-bit words from a synchronous ROM, hands each one
// to the control unit with a run pulse and waits for done, with stop/HALT/watchdog handling.
module instr_fetch_unit #(
   parameter int                  INSTR_W  = instr_fetch_unit_pkg::INSTR_W,
   parameter int                  ADDR_W   = 8,
   parameter int                  PROG_LEN = 256,
   parameter logic [INSTR_W-1:0]  HALT_OP  = INSTR_W'(instr_fetch_unit_pkg::HALT_OP),
   parameter int                  TIMEOUT  = 15
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_start,
   input  logic                               i_stop,
   output logic                               o_mem_rd_en,
   output logic [ADDR_W-1:0]                  o_mem_addr,
   input  logic [INSTR_W-1:0]                 i_mem_rdata,
   output logic [INSTR_W-1:0]                 o_instruction,
   output logic                               o_run,
   input  logic                               i_done,
   output logic [ADDR_W-1:0]                  o_pc,
   output logic                               o_busy,
   output logic                               o_halted,
   output logic                               o_wd_err,
   output instr_fetch_unit_pkg::fetch_state_t o_state
);

   import instr_fetch_unit_pkg::*;

   localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_LEN - 1);

   fetch_state_t       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instruction;
   logic               r_stop_pend;
   logic               r_wd_err;
   logic               r_halt_op;

   fetch_state_t       w_state_nxt;
   logic [ADDR_W-1:0]  w_pc_nxt;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic               w_stop_pend_nxt;
   logic               w_wd_err_nxt;
   logic               w_halt_op_nxt;
   logic               w_busy;
   logic               w_wd_clear;
   logic               w_wd_en;
   logic               w_timeout;

   fetch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (w_wd_clear),
      .i_enable  (w_wd_en),
      .o_timeout (w_timeout)
   );

   // Wrap is taken at the last valid program word, not at the end of the address space.
   assign w_pc_inc = (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
   assign w_busy   = (r_state == ST_FETCH) || (r_state == ST_WAIT_MEM) ||
                     (r_state == ST_ISSUE) || (r_state == ST_EXEC);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_pc          <= '0;
         r_instruction <= '0;
         r_stop_pend   <= 1'b0;
         r_wd_err      <= 1'b0;
         r_halt_op     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instruction <= w_instr_nxt;
         r_stop_pend   <= w_stop_pend_nxt;
         r_wd_err      <= w_wd_err_nxt;
         r_halt_op     <= w_halt_op_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_instr_nxt     = r_instruction;
      w_stop_pend_nxt = r_stop_pend;
      w_wd_err_nxt    = r_wd_err;
      w_halt_op_nxt   = r_halt_op;
      w_wd_clear      = 1'b0;
      w_wd_en         = 1'b0;

      if (w_busy && i_stop) begin
         w_stop_pend_nxt = 1'b1;
      end

      unique case (r_state)
         ST_IDLE, ST_HALTED: begin
            if (i_start) begin
               w_state_nxt     = ST_FETCH;
               w_wd_err_nxt    = 1'b0;
               w_stop_pend_nxt = i_stop;
               // Resume past a HALT word; after a stop or watchdog the pc is already right.
               if (r_halt_op) begin
                  w_pc_nxt      = w_pc_inc;
                  w_halt_op_nxt = 1'b0;
               end
            end
         end
         ST_FETCH: begin
            w_state_nxt = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            if (i_mem_rdata == HALT_OP) begin
               w_state_nxt     = ST_HALTED;
               w_halt_op_nxt   = 1'b1;
               w_stop_pend_nxt = 1'b0;
            end else begin
               w_instr_nxt = i_mem_rdata;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_wd_clear  = 1'b1;
            w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            w_wd_en = 1'b1;
            if (i_done) begin
               w_pc_nxt = w_pc_inc;
               if (r_stop_pend || i_stop) begin
                  w_state_nxt     = ST_HALTED;
                  w_stop_pend_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_FETCH;
               end
            end else if (w_timeout) begin
               w_wd_err_nxt    = 1'b1;
               w_state_nxt     = ST_HALTED;
               w_stop_pend_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_mem_rd_en   = (r_state == ST_FETCH);
   assign o_mem_addr    = r_pc;
   assign o_instruction = r_instruction;
   assign o_run         = (r_state == ST_ISSUE);
   assign o_pc          = r_pc;
   assign o_busy        = w_busy;
   assign o_halted      = (r_state == ST_HALTED);
   assign o_wd_err      = r_wd_err;
   assign o_state       = r_state;

endmodule
